// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions for the register-bank read path.
// Provides response codes, the read-path occupancy state encoding and
// helpers that derive address/index widths from block parameters.
package axi4lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Occupancy of the read path, encoded as {skid_full, rvalid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    RD_EMPTY = 2'b00,
    RD_ONE   = 2'b01,
    RD_FULL  = 2'b11
  } rd_state_e;

  // Number of byte-offset bits below the word index.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Width of a register index, never less than one bit.
  function automatic int unsigned index_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axi4lite_reg_reader_if.sv
// AXI4-Lite read-channel bundle (AR + R).
// master: drives araddr/arprot/arvalid/rready; slave: drives arready/rdata/rresp/rvalid.
interface axi4lite_reg_reader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [2:0]            s_axi_arprot;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/axi4lite_ar_skid.sv
// One-entry AR address skid with registered ready.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   capture     - store in_addr into the skid this edge
//   full_next   - skid occupancy after this edge; ready is its registered inverse
//   in_addr     - address presented on the AR channel
//   skid_addr   - stored address
//   ready       - registered AR ready (low during reset, high one edge after)
module axi4lite_ar_skid #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  full_next,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] skid_addr,
  output logic                  ready
);

  // Address storage and ready register; ready never depends on rready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_addr <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= !full_next;
      if (capture) begin
        skid_addr <= in_addr;
      end
    end
  end

endmodule

// File: rtl/axi4lite_reg_reader.sv
// AXI4-Lite read responder for the generated register bank.
// Accepts AR beats, decodes the word index, samples the flat register bus
// when the beat is loaded into R and returns OKAY or SLVERR. Full throughput
// with a one-entry address skid so arready stays registered.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   s_axi        - AXI4-Lite read channels (slave modport)
//   reg_data_i   - flat register bank, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_strobe_o  - one-cycle pulse aligned with the first R cycle of an in-range beat
//   rd_index_o   - register index qualified by rd_strobe_o
module axi4lite_reg_reader
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  axi4lite_reg_reader_if.slave               s_axi,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     reg_data_i,
  output logic                               rd_strobe_o,
  output logic [index_width(NUM_REGS)-1:0]   rd_index_o
);

  localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int unsigned SEL_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned IDX_W    = index_width(NUM_REGS);

  rd_state_e             state;
  rd_state_e             state_next;
  logic                  rvalid;
  logic                  arready;
  logic                  rready;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SEL_W-1:0]      sel_idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] bank_word;
  logic                  load_r_c;
  logic                  capture_c;
  logic                  use_skid_c;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  unused_ok;

  assign rready = s_axi.s_axi_rready;
  assign ar_hs  = s_axi.s_axi_arvalid && arready;
  assign rvalid = (state != RD_EMPTY);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; arready is low in RD_FULL so no AR handshake occurs there.
  always_comb begin
    state_next = state;
    case (state)
      RD_EMPTY: begin
        if (ar_hs) state_next = RD_ONE;
      end
      RD_ONE: begin
        if (ar_hs && !rready)      state_next = RD_FULL;
        else if (!ar_hs && rready) state_next = RD_EMPTY;
      end
      RD_FULL: begin
        if (rready) state_next = RD_ONE;
      end
      default: state_next = RD_EMPTY;
    endcase
  end

  // Datapath controls: load R when the output is free, park the address otherwise.
  always_comb begin
    load_r_c   = 1'b0;
    capture_c  = 1'b0;
    use_skid_c = 1'b0;
    case (state)
      RD_EMPTY: begin
        load_r_c = ar_hs;
      end
      RD_ONE: begin
        load_r_c  = ar_hs && rready;
        capture_c = ar_hs && !rready;
      end
      RD_FULL: begin
        load_r_c   = rready;
        use_skid_c = 1'b1;
      end
      default: begin
        load_r_c = 1'b0;
      end
    endcase
  end

  axi4lite_ar_skid #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ar_skid (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture_c),
    .full_next (state_next == RD_FULL),
    .in_addr   (s_axi.s_axi_araddr),
    .skid_addr (skid_addr),
    .ready     (arready)
  );

  // Address decode; byte-offset bits are ignored so misaligned reads are legal.
  assign sel_addr = use_skid_c ? skid_addr : s_axi.s_axi_araddr;
  assign sel_idx  = sel_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign in_range = (32'(sel_idx) < NUM_REGS);

  // Bank mux; out-of-range indices match no entry and read as zero.
  always_comb begin
    bank_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        bank_word = reg_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // R payload and read strobe, all updated on the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q     <= '0;
      rresp_q     <= AXI_RESP_OKAY;
      rd_strobe_o <= 1'b0;
      rd_index_o  <= '0;
    end else begin
      rd_strobe_o <= load_r_c && in_range;
      if (load_r_c) begin
        rdata_q <= in_range ? bank_word : '0;
        rresp_q <= in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (in_range) begin
          rd_index_o <= IDX_W'(sel_idx);
        end
      end
    end
  end

  assign s_axi.s_axi_arready = arready;
  assign s_axi.s_axi_rvalid  = rvalid;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  // arprot and the byte-offset bits carry no meaning for this block.
  assign unused_ok = ^{s_axi.s_axi_arprot, sel_addr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4lite_reg_reader.sv
// Self-checking bench for axi4lite_reg_reader: directed steps followed by
// randomized traffic, checked against an in-order queue of accepted addresses.
module tb_axi4lite_reg_reader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR*DW-1:0] reg_data;
  logic            rd_strobe;
  logic [3:0]      rd_index;
  logic [DW-1:0]   bank [NR];

  always #5 clk = ~clk;

  axi4lite_reg_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4lite_reg_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axi       (bus),
    .reg_data_i  (reg_data),
    .rd_strobe_o (rd_strobe),
    .rd_index_o  (rd_index)
  );

  always_comb begin
    for (int i = 0; i < NR; i++) reg_data[i*DW +: DW] = bank[i];
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  bit         rst_last;
  bit         new_first;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [7:0] a);
    return a[7:2] < 6'd16;
  endfunction

  function automatic bit exp_arready();
    return !rst_last && (q.size() < 2);
  endfunction

  // Compare every observable output against the reference queue.
  task automatic check_outputs();
    logic [7:0] a;
    check("arready", 64'(bus.s_axi_arready), 64'(exp_arready()));
    check("rvalid", 64'(bus.s_axi_rvalid), 64'(q.size() > 0));
    if (rst_last) begin
      check("rst_rdata", 64'(bus.s_axi_rdata), 64'd0);
      check("rst_rresp", 64'(bus.s_axi_rresp), 64'd0);
      check("rst_strobe", 64'(rd_strobe), 64'd0);
      check("rst_index", 64'(rd_index), 64'd0);
    end else if (q.size() > 0) begin
      a = q[0];
      check("rdata", 64'(bus.s_axi_rdata), in_rng(a) ? 64'(bank[a[5:2]]) : 64'd0);
      check("rresp", 64'(bus.s_axi_rresp), in_rng(a) ? 64'd0 : 64'd2);
      check("rd_strobe", 64'(rd_strobe), 64'(new_first && in_rng(a)));
      if (new_first && in_rng(a)) check("rd_index", 64'(rd_index), 64'(a[5:2]));
    end else begin
      check("idle_strobe", 64'(rd_strobe), 64'd0);
    end
  endtask

  // One clock: check at negedge, drive, advance the model across the posedge.
  task automatic step(input bit av, input logic [7:0] ad, input bit rr, input bit rs);
    bit ar_hs, r_hs, was_empty;
    check_outputs();
    bus.s_axi_arvalid = av;
    bus.s_axi_araddr  = ad;
    bus.s_axi_rready  = rr;
    bus.s_axi_arprot  = 3'($urandom);
    reset             = rs;
    ar_hs     = av && exp_arready() && !rs;
    r_hs      = rr && (q.size() > 0) && !rs;
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (rs) begin
      q.delete();
      rst_last  = 1'b1;
      new_first = 1'b0;
    end else begin
      rst_last = 1'b0;
      if (r_hs) void'(q.pop_front());
      if (ar_hs) q.push_back(ad);
      new_first = (r_hs || was_empty) && (q.size() > 0);
    end
    @(negedge clk);
  endtask

  initial begin
    bit         av, rr, pend, acc;
    logic [7:0] ad;

    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arprot  = '0;
    bus.s_axi_rready  = 1'b0;
    for (int i = 0; i < NR; i++) bank[i] = 32'h1000_0000 + 32'(i);
    bank[2]   = 32'hDEAD_BEEF;
    rst_last  = 1'b1;
    new_first = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset, release, arready rises one edge later.
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    check("arready_after_release", 64'(bus.s_axi_arready), 64'd1);

    // Single read, out-of-range read, misaligned read.
    step(1, 8'h08, 1, 0);
    check("single_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
    check("single_rdata", 64'(bus.s_axi_rdata), 64'hDEAD_BEEF);
    check("single_strobe", 64'(rd_strobe), 64'd1);
    check("single_index", 64'(rd_index), 64'd2);
    step(1, 8'h40, 1, 0);
    check("oor_rdata", 64'(bus.s_axi_rdata), 64'd0);
    check("oor_rresp", 64'(bus.s_axi_rresp), 64'd2);
    check("oor_strobe", 64'(rd_strobe), 64'd0);
    step(1, 8'h0B, 1, 0);
    check("misaligned_rdata", 64'(bus.s_axi_rdata), 64'hDEAD_BEEF);
    check("misaligned_rresp", 64'(bus.s_axi_rresp), 64'd0);
    step(0, 8'h00, 1, 0);

    // Backpressure: second read parks in the skid; data sampled at R load.
    step(1, 8'h04, 0, 0);
    step(1, 8'h0C, 0, 0);
    check("bp_arready_low", 64'(bus.s_axi_arready), 64'd0);
    check("bp_first_rdata", 64'(bus.s_axi_rdata), 64'(bank[1]));
    bank[3] = 32'hCAFE_F00D;
    step(0, 8'h00, 1, 0);
    check("bp_second_rdata", 64'(bus.s_axi_rdata), 64'hCAFE_F00D);
    check("bp_second_index", 64'(rd_index), 64'd3);
    check("bp_arready_back", 64'(bus.s_axi_arready), 64'd1);
    step(0, 8'h00, 1, 0);

    // Streaming: one beat per clock with no bubbles.
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i * 4), 1, 0);
      check("stream_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
      check("stream_rdata", 64'(bus.s_axi_rdata), 64'(bank[i]));
    end
    step(0, 8'h00, 1, 0);

    // Reset while full with rready low discards everything.
    step(1, 8'h04, 0, 0);
    step(1, 8'h08, 0, 0);
    step(0, 8'h00, 0, 1);
    check("rstfull_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
    check("rstfull_strobe", 64'(rd_strobe), 64'd0);
    bank[5] = $urandom;
    step(0, 8'h00, 0, 0);
    step(1, 8'h14, 1, 0);
    check("rstfull_fresh", 64'(bus.s_axi_rdata), 64'(bank[5]));
    step(0, 8'h00, 1, 0);

    // Randomized traffic; bank held constant within each phase.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < NR; i++) bank[i] = $urandom;
      pend = 1'b0;
      av   = 1'b0;
      ad   = '0;
      for (int c = 0; c < 200; c++) begin
        if (!pend) begin
          av = 1'($urandom_range(0, 1));
          ad = 8'($urandom);
        end
        rr  = ($urandom_range(0, 3) != 0);
        acc = av && exp_arready();
        step(av, ad, rr, 0);
        pend = av && !acc;
      end
      for (int c = 0; c < 4; c++) step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_reader.md
Name: axi4lite_reg_reader

Overview:
- AXI4-Lite read-channel responder for the generated register bank: accepts AR beats, decodes the word index, samples the flat register-bank bus and returns an R beat with OKAY or SLVERR.
- Read-side counterpart of the per-register write/hold storage; sits between the AXI4-Lite slave port and the register-bank outputs.
- Emits a one-cycle read strobe per returned beat so clear-on-read or status registers can react.
- Full throughput (one beat per clock), registered ARREADY via a one-entry address skid.

Parameters:
- ADDR_WIDTH, 8, byte-address width of ARADDR.
- DATA_WIDTH, 32, register and RDATA width; 32 or 64 only.
- NUM_REGS, 16, number of implemented registers; 1..2^(ADDR_WIDTH-ADDR_LSB).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready (registered).
- s_axi_rdata  out  DATA_WIDTH  read data (registered).
- s_axi_rresp  out  2  read response (registered).
- s_axi_rvalid  out  1  R valid (registered).
- s_axi_rready  in  1  R ready.
- reg_data_i  in  NUM_REGS*DATA_WIDTH  flat bank; register k is slice [k*DATA_WIDTH +: DATA_WIDTH].
- rd_strobe_o  out  1  one-cycle pulse when a valid-index beat is loaded into R.
- rd_index_o  out  clog2(NUM_REGS) (min 1)  index qualified by rd_strobe_o.

Behaviour:
- ADDR_LSB = clog2(DATA_WIDTH/8).
- Index = araddr[ADDR_WIDTH-1:ADDR_LSB]; low address bits are ignored, so misaligned reads are not errors.
- Index < NUM_REGS: rdata = register slice, rresp = OKAY (2'b00), strobe pulses.
- Index >= NUM_REGS: rdata = 0, rresp = SLVERR (2'b10), no strobe.
- Reset (synchronous, any cycle, including mid-transfer):
  - rvalid=0, rdata=0, rresp=0, arready=0, skid_full=0, rd_strobe_o=0, rd_index_o=0.
  - Any pending beat or skid entry is discarded.
  - arready rises to 1 on the first clock edge after reset deasserts.
- Handshakes:
  - AR handshake = arvalid & arready.
  - R handshake = rvalid & rready.
  - rvalid, once high, stays high with rdata/rresp stable until the R handshake.
- out_free = !rvalid | rready.
- States, encoded as {skid_full, rvalid}:
  - EMPTY {0,0}, ONE {0,1}, FULL {1,1}.
  - {1,0} is unreachable.
- Transitions per clock:
  - AR handshake with out_free: decode the address and sample reg_data_i this edge; load R next cycle (rvalid=1).
    - Latency: AR handshake to rvalid is 1 cycle.
  - AR handshake with !out_free: store araddr in the skid; skid_full<=1; arready<=0.
  - skid_full with out_free: decode the skid address and sample reg_data_i at this edge; load R; skid_full<=0; arready<=1.
    - Data is sampled when loaded into R, not at AR acceptance.
  - R handshake with nothing to load: rvalid<=0.
- arready = !skid_full (registered), so there is no combinational path from rready to arready.
- Simultaneous AR handshake and R handshake in ONE: new beat replaces the old one; rvalid stays 1; no bubble.
- rd_strobe_o/rd_index_o are registered and asserted in the same cycle the new beat first appears on R (aligned with the rvalid cycle of that beat).
- Back-to-back reads with rready held high: one beat per clock, steady state.
- arprot is unused.
- No write-channel logic in this block.

Decomposition:
- Package axi4lite_pkg:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - function addr_lsb(DATA_WIDTH).
  - function index_width(NUM_REGS).
- One natural sub-module: axi4lite_ar_skid, a one-entry address skid buffer with registered ready.
- Decode, bank mux and R output register stay in the top.

Test Plan:
- Reset then idle: rvalid=0, rdata=0, arready=0 during reset; arready=1 one cycle after release.
- Single read araddr=0x08, reg2=0xDEADBEEF, rready=1: next cycle rvalid=1, rdata=0xDEADBEEF, rresp=00; rd_strobe_o=1 with rd_index_o=2 in that cycle.
- Out-of-range read araddr=0x40 with NUM_REGS=16: rdata=0, rresp=10, no rd_strobe_o. Misaligned 0x0B returns reg2 with OKAY.
- Backpressure: rready=0, reads to 0x04 then 0x0C.
  - Second read is captured in the skid; arready drops to 0.
  - Change reg3 before releasing rready: beats return reg1 then the new reg3 value, in order.
  - arready returns to 1 after the skid drains.
- Streaming: 8 consecutive reads with arvalid and rready held high give 8 beats on 8 consecutive cycles with matching data and no bubbles.
- Reset asserted while in FULL with rready=0: next cycle rvalid=0, skid empty, strobe 0; the next read after release returns fresh data only.
